// File: rtl/wb_pkg.sv
// Shared encodings and queue entry layout for the write-back stage.
// Optional LOAD_EXT_EN adds the byte/half size and sign fields to each entry.
package wb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned NREGS  = 32;

  localparam logic [1:0] KIND_NONE = 2'b00;
  localparam logic [1:0] KIND_ALU  = 2'b01;
  localparam logic [1:0] KIND_LUI  = 2'b10;
  localparam logic [1:0] KIND_LOAD = 2'b11;

  localparam logic [1:0] RW_NONE  = 2'b00;
  localparam logic [1:0] RW_WRITE = 2'b01;
  localparam logic [1:0] RW_LUI   = 2'b10;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef struct packed {
    logic [1:0]        kind;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
`ifdef LOAD_EXT_EN
    logic [1:0]        size;
    logic              sgn;
`endif
    logic              ready;
  } entry_t;

  // Register-file write code for a retiring entry; r0 and bubbles never write.
  function automatic logic [1:0] rw_code(input logic [1:0] kind, input logic [REG_W-1:0] rd);
    if (kind == KIND_NONE || rd == '0) return RW_NONE;
    if (kind == KIND_LUI) return RW_LUI;
    return RW_WRITE;
  endfunction

endpackage

// File: rtl/wb_load_ext.sv
// Byte/half right-aligned load extension; only built when LOAD_EXT_EN is defined.
`ifdef LOAD_EXT_EN
module wb_load_ext
  import wb_pkg::*;
(
  input  logic [1:0]        size,
  input  logic              sgn,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] ext_c
);

  always_comb begin
    ext_c = rdata;
    case (size)
      SIZE_BYTE: ext_c = {{24{sgn & rdata[7]}}, rdata[7:0]};
      SIZE_HALF: ext_c = {{16{sgn & rdata[15]}}, rdata[15:0]};
      default:   ext_c = rdata;
    endcase
  end

endmodule
`endif

// File: rtl/wb_writer.sv
// Write-back stage: in-order retire queue, in-order load fill, register-file write port.
// Define LOAD_EXT_EN to enable byte/half loads with optional sign extension.
module wb_writer
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_size,
  input  logic              in_signed,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        wb_regwrite,
  output logic [REG_W-1:0]  wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [NREGS-1:0]  pending_mask,
  output logic              err_sticky
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  entry_t            q [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [PTR_W-1:0]  head, tail, fill_ptr, fill_ptr_nxt;
  logic [CNT_W-1:0]  count, count_nxt, ld_cnt, ld_cnt_nxt;

  logic              enq, enq_load, fill, retire;
  entry_t            new_entry;
  logic [DATA_W-1:0] fill_data;
  logic              nxt_found;
  logic [PTR_W-1:0]  nxt_idx, scan_idx;

  assign in_ready = (count != CNT_W'(DEPTH));
  assign enq      = in_valid && in_ready;
  assign enq_load = enq && (in_kind == KIND_LOAD);
  // Only loads already queued before this edge are eligible for a beat.
  assign fill     = mem_rvalid && (ld_cnt != '0);
  assign retire   = valid[head] && q[head].ready;

`ifdef LOAD_EXT_EN
  wb_load_ext u_ext (
    .size  (q[fill_ptr].size),
    .sgn   (q[fill_ptr].sgn),
    .rdata (mem_rdata),
    .ext_c (fill_data)
  );
`else
  logic unused_load_cfg;
  assign unused_load_cfg = ^{in_size, in_signed};
  assign fill_data       = mem_rdata;
`endif

  // Entry as written at the tail.
  always_comb begin
    new_entry       = '0;
    new_entry.kind  = in_kind;
    new_entry.rd    = in_rd;
    new_entry.data  = (in_kind == KIND_LOAD) ? '0 : in_data;
`ifdef LOAD_EXT_EN
    new_entry.size  = in_size;
    new_entry.sgn   = in_signed;
`endif
    new_entry.ready = (in_kind != KIND_LOAD);
  end

  // Next unfilled load after the current fill target, nearest first.
  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = fill_ptr;
    scan_idx  = fill_ptr;
    for (int k = int'(DEPTH) - 1; k >= 1; k--) begin
      scan_idx = fill_ptr + PTR_W'(k);
      if (valid[scan_idx] && q[scan_idx].kind == KIND_LOAD && !q[scan_idx].ready) begin
        nxt_found = 1'b1;
        nxt_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    fill_ptr_nxt = fill_ptr;
    if (fill) begin
      if (nxt_found)     fill_ptr_nxt = nxt_idx;
      else if (enq_load) fill_ptr_nxt = tail;
    end else if (ld_cnt == '0 && enq_load) begin
      fill_ptr_nxt = tail;
    end

    count_nxt = count;
    if (enq && !retire)      count_nxt = count + CNT_W'(1);
    else if (!enq && retire) count_nxt = count - CNT_W'(1);

    ld_cnt_nxt = ld_cnt;
    if (enq_load && !fill)      ld_cnt_nxt = ld_cnt + CNT_W'(1);
    else if (!enq_load && fill) ld_cnt_nxt = ld_cnt - CNT_W'(1);
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid[i] && q[i].kind != KIND_NONE) pending_mask[q[i].rd] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) q[i] <= '0;
      valid       <= '0;
      head        <= '0;
      tail        <= '0;
      fill_ptr    <= '0;
      count       <= '0;
      ld_cnt      <= '0;
      wb_regwrite <= RW_NONE;
      wb_addr     <= '0;
      wb_data     <= '0;
      err_sticky  <= 1'b0;
    end else begin
      if (enq) begin
        q[tail]     <= new_entry;
        valid[tail] <= 1'b1;
        tail        <= tail + PTR_W'(1);
      end
      if (fill) begin
        q[fill_ptr].data  <= fill_data;
        q[fill_ptr].ready <= 1'b1;
      end
      if (retire) begin
        valid[head] <= 1'b0;
        head        <= head + PTR_W'(1);
        wb_regwrite <= rw_code(q[head].kind, q[head].rd);
        wb_addr     <= q[head].rd;
        wb_data     <= q[head].data;
      end else begin
        wb_regwrite <= RW_NONE;
      end
      if (mem_rvalid && !fill) err_sticky <= 1'b1;
      fill_ptr <= fill_ptr_nxt;
      count    <= count_nxt;
      ld_cnt   <= ld_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_wb_writer.sv
// Bench for wb_writer: directed steps plus random traffic against a queue-based reference model.
// Byte/half extension checks are included when LOAD_EXT_EN is defined.
module tb_wb_writer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_kind;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic [1:0]  in_size;
  logic        in_signed;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  wb_regwrite;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] pending_mask;
  logic        err_sticky;

  wb_writer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_kind      (in_kind),
    .in_rd        (in_rd),
    .in_data      (in_data),
    .in_size      (in_size),
    .in_signed    (in_signed),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .wb_regwrite  (wb_regwrite),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .pending_mask (pending_mask),
    .err_sticky   (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [1:0]  size;
    logic        sgn;
    bit          ready;
  } ment_t;

  ment_t       mq[$];
  logic [1:0]  exp_rw;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  logic        exp_err;
  bit          last_acc;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mext(input logic [1:0] sz, input logic sg, input logic [31:0] d);
`ifdef LOAD_EXT_EN
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = d & 32'h0000_00FF;
      if (sg && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = d & 32'h0000_FFFF;
      if (sg && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = d;
    end
    return v;
`else
    return d;
`endif
  endfunction

  function automatic logic [31:0] mpend();
    logic [31:0] m;
    m = '0;
    foreach (mq[i]) if (mq[i].kind != 2'b00) m[mq[i].rd] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  function automatic bit has_unfilled();
    foreach (mq[i]) if (mq[i].kind == 2'b11 && !mq[i].ready) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: predict from pre-edge inputs/model, then compare just after the edge.
  task automatic tick();
    int    fi;
    bit    ret;
    ment_t e;
    chk("in_ready", in_ready, 32'(mq.size() < DEPTH));
    last_acc = in_valid && (mq.size() < DEPTH);
    ret = (mq.size() > 0) && mq[0].ready;
    fi = -1;
    foreach (mq[i]) if (fi < 0 && mq[i].kind == 2'b11 && !mq[i].ready) fi = i;
    if (mem_rvalid) begin
      if (fi >= 0) begin
        e = mq[fi];
        e.data = mext(e.size, e.sgn, mem_rdata);
        e.ready = 1'b1;
        mq[fi] = e;
      end else begin
        exp_err = 1'b1;
      end
    end
    if (ret) begin
      e = mq.pop_front();
      exp_addr = e.rd;
      exp_data = e.data;
      if (e.kind == 2'b00 || e.rd == 5'd0) exp_rw = 2'b00;
      else if (e.kind == 2'b10)            exp_rw = 2'b10;
      else                                 exp_rw = 2'b01;
    end else begin
      exp_rw = 2'b00;
    end
    if (last_acc) begin
      e.kind  = in_kind;
      e.rd    = in_rd;
      e.data  = (in_kind == 2'b11) ? 32'h0 : in_data;
      e.size  = in_size;
      e.sgn   = in_signed;
      e.ready = (in_kind != 2'b11);
      mq.push_back(e);
    end
    @(posedge clk);
    #1;
    chk("wb_regwrite", wb_regwrite, exp_rw);
    chk("wb_addr", wb_addr, exp_addr);
    chk("wb_data", wb_data, exp_data);
    chk("pending_mask", pending_mask, mpend());
    chk("err_sticky", err_sticky, exp_err);
  endtask

  task automatic drive(input logic v, input logic [1:0] k, input logic [4:0] r,
                       input logic [31:0] d, input logic [1:0] sz, input logic sg);
    in_valid = v; in_kind = k; in_rd = r; in_data = d; in_size = sz; in_signed = sg;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 5'd0, 32'h0, 2'b00, 1'b0);
    mem_rvalid = 1'b0;
  endtask

  task automatic drain();
    idle();
    for (int n = 0; n < 4 * DEPTH + 8 && mq.size() > 0; n++) begin
      mem_rvalid = has_unfilled();
      mem_rdata  = $urandom;
      tick();
    end
    mem_rvalid = 1'b0;
    chk("drain_pending", pending_mask, 32'h0);
    chk("drain_ready", in_ready, 32'h1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit accepted;
    rst_n = 1'b0;
    idle();
    mem_rdata = '0;
    exp_rw = 2'b00; exp_addr = '0; exp_data = '0; exp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", in_ready, 32'h1);
    chk("rst_rw", wb_regwrite, 32'h0);
    chk("rst_addr", wb_addr, 32'h0);
    chk("rst_data", wb_data, 32'h0);
    chk("rst_pending", pending_mask, 32'h0);
    chk("rst_err", err_sticky, 32'h0);
    rst_n = 1'b1;

    // ALU into empty queue: written one edge after acceptance.
    drive(1'b1, 2'b01, 5'd8, 32'h0000_0005, 2'b10, 1'b0);
    tick();
    chk("alu_pend", pending_mask, 32'h0000_0100);
    idle(); tick();
    chk("alu_rw", wb_regwrite, 32'h1);
    chk("alu_addr", wb_addr, 32'd8);
    chk("alu_data", wb_data, 32'h5);
    tick();
    chk("alu_rw_off", wb_regwrite, 32'h0);

    // LUI then ALU to r0.
    drive(1'b1, 2'b10, 5'd9, 32'h0000_1234, 2'b10, 1'b0); tick();
    drive(1'b1, 2'b01, 5'd0, 32'h0000_0077, 2'b10, 1'b0); tick();
    chk("lui_rw", wb_regwrite, 32'h2);
    chk("lui_addr", wb_addr, 32'd9);
    chk("lui_lo", 32'(wb_data[15:0]), 32'h1234);
    idle(); tick();
    chk("r0_rw", wb_regwrite, 32'h0);

    // LOAD r10 followed by ALU r11; the beat arrives late.
    drive(1'b1, 2'b11, 5'd10, 32'hAAAA_AAAA, 2'b10, 1'b0); tick();
    drive(1'b1, 2'b01, 5'd11, 32'h0000_0011, 2'b10, 1'b0); tick();
    chk("ld_pend2", pending_mask, 32'h0000_0C00);
    idle(); tick(); tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; tick();
    chk("ld_pend_fill", pending_mask, 32'h0000_0C00);
    mem_rvalid = 1'b0; tick();
    chk("ld_rw", wb_regwrite, 32'h1);
    chk("ld_addr", wb_addr, 32'd10);
    chk("ld_data", wb_data, 32'hDEAD_BEEF);
    chk("ld_pend1", pending_mask, 32'h0000_0800);
    tick();
    chk("ld_next_addr", wb_addr, 32'd11);

    // Fill the queue behind an unfilled load; the fifth entry must wait.
    drive(1'b1, 2'b11, 5'd1, 32'h0, 2'b10, 1'b0); tick();
    drive(1'b1, 2'b01, 5'd2, 32'h22, 2'b10, 1'b0); tick();
    drive(1'b1, 2'b01, 5'd3, 32'h33, 2'b10, 1'b0); tick();
    drive(1'b1, 2'b01, 5'd4, 32'h44, 2'b10, 1'b0); tick();
    chk("full_ready", in_ready, 32'h0);
    drive(1'b1, 2'b01, 5'd5, 32'h55, 2'b10, 1'b0);
    accepted = 1'b0;
    for (int n = 0; n < 10 && !accepted; n++) begin
      mem_rvalid = (n == 2);
      mem_rdata  = 32'h0000_0101;
      tick();
      accepted = last_acc;
    end
    chk("fifth_accepted", 32'(accepted), 32'h1);
    drain();

    // Spurious beat on an empty queue.
    mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF; tick();
    chk("err_set", err_sticky, 32'h1);
    chk("err_nowrite", wb_regwrite, 32'h0);
    mem_rvalid = 1'b0;

    // Asynchronous reset with entries in flight.
    drive(1'b1, 2'b11, 5'd7, 32'h0, 2'b10, 1'b0); tick();
    drive(1'b1, 2'b01, 5'd6, 32'h66, 2'b10, 1'b0); tick();
    idle();
    rst_n = 1'b0;
    #1;
    chk("arst_err", err_sticky, 32'h0);
    chk("arst_rw", wb_regwrite, 32'h0);
    chk("arst_pending", pending_mask, 32'h0);
    chk("arst_ready", in_ready, 32'h1);
    mq.delete();
    exp_rw = 2'b00; exp_addr = '0; exp_data = '0; exp_err = 1'b0;
    #2;
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h2468_ACE0; tick();
    chk("arst_beat_forgotten", err_sticky, 32'h1);
    idle();

`ifdef LOAD_EXT_EN
    drive(1'b1, 2'b11, 5'd12, 32'h0, 2'b00, 1'b1); tick();
    idle(); mem_rvalid = 1'b1; mem_rdata = 32'h0000_0080; tick();
    mem_rvalid = 1'b0; tick();
    chk("ext_byte_s", wb_data, 32'hFFFF_FF80);
    drive(1'b1, 2'b11, 5'd13, 32'h0, 2'b01, 1'b0); tick();
    idle(); mem_rvalid = 1'b1; mem_rdata = 32'h1234_8001; tick();
    mem_rvalid = 1'b0; tick();
    chk("ext_half_u", wb_data, 32'h0000_8001);
`endif

    // Random traffic against the model.
    for (int n = 0; n < 500; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 5'($urandom),
            $urandom, 2'($urandom_range(0, 2)), 1'($urandom));
      mem_rvalid = has_unfilled() ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 49) == 0);
      mem_rdata  = $urandom;
      tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_writer.md
Name: wb_writer

Overview:
- Write-back stage of the 32-bit MIPS pipeline; the producer side of the register-file write port.
- Accepts retiring instructions from the MEM stage and collects in-order load data from data memory.
- Drives the register file's write code, address and data, one write per cycle, in program order.
- Exports a pending-write scoreboard so the hazard unit can stall on in-flight destinations.

Parameters:
- DEPTH, 4, entries in the in-order retire queue; power of two, >= 2.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  queue can accept an entry (count < DEPTH).
- in_kind  in  2  00 none, 01 ALU, 10 LUI, 11 LOAD.
- in_rd  in  5  destination register.
- in_data  in  32  ALU result, or immediate in bits [15:0] for LUI; ignored for LOAD.
- in_size  in  2  load size: 00 byte, 01 half, 10 word.
- in_signed  in  1  sign-extend a sub-word load.
- mem_rvalid  in  1  load data beat; one per LOAD, returned in issue order.
- mem_rdata  in  32  load data, right-aligned.
- wb_regwrite  out  2  register-file write code: 00 none, 01 write, 10 LUI (register file places data[15:0] in the upper half), 11 write.
- wb_addr  out  5  write address.
- wb_data  out  32  write data.
- pending_mask  out  32  bit r set while any queued entry targets r; bit 0 always 0.
- err_sticky  out  1  set on mem_rvalid with no outstanding load; cleared only by reset.

Behaviour:
- Reset values: queue empty, in_ready=1, wb_regwrite=00, wb_addr=0, wb_data=0, pending_mask=0, err_sticky=0.
- Reset is asynchronous and may assert mid-operation: queued entries are discarded and outstanding load beats are forgotten.

Queue:
- Circular buffer of DEPTH entries with head pointer, tail pointer and count. Pointers wrap modulo DEPTH.
- Each entry holds {kind, rd, data, size, signed, ready}.

Enqueue:
- Occurs on posedge when in_valid && in_ready.
- kind 00 is accepted and occupies a slot. It retires with a 00 code and does not mark pending_mask.
- ALU and LUI entries are enqueued with ready=1.
- LOAD entries are enqueued with ready=0 and data=0.

Load fill:
- On mem_rvalid, mem_rdata (after extension) is written into the oldest LOAD entry with ready=0, and that entry's ready is set.
- A separate fill pointer tracks that entry.
- A beat may fill an entry enqueued in the same cycle only if it was already in the queue before the edge; otherwise the beat is an error.
- mem_rvalid with no unfilled load sets err_sticky and is dropped.

Retire:
- At most one per cycle, always from the head, only when the head has ready=1.
- On retire, the registered outputs take the following values on the same edge:
  - wb_addr = rd, wb_data = data.
  - wb_regwrite = 01 for ALU/LOAD, 10 for LUI.
  - wb_regwrite = 00 if kind=00 or rd=0.
- In every cycle with no retire, wb_regwrite=00 and wb_addr/wb_data hold their previous values.
- Outputs change only on posedge, so they are stable at the register file's negedge write.

Latency and throughput:
- ALU entry into an empty queue at edge N: written out at edge N+1.
- LOAD entry: written out on the edge after its fill.
- Sustained throughput is one per cycle.

Concurrency and boundaries:
- Simultaneous enqueue, fill and retire in one cycle are all legal. count is adjusted by +1, 0 or -1.
- When full, in_ready=0 even if the head retires this cycle (no combinational ready path).
- pending_mask is combinational from queue contents (OR of rd over valid entries with kind!=00), bit 0 forced 0.

Optional Feature:
- Macro LOAD_EXT_EN.
- Defined:
  - byte uses mem_rdata[7:0]; half uses mem_rdata[15:0].
  - Zero-extended, or sign-extended when in_signed=1.
- Undefined:
  - size and signed are not stored; all loads are word loads and mem_rdata is written unchanged.
  - in_size and in_signed remain as ports and are ignored.

Decomposition:
- Package wb_pkg holds:
  - kind encodings: KIND_NONE, KIND_ALU, KIND_LUI, KIND_LOAD.
  - regwrite codes: RW_NONE=00, RW_WRITE=01, RW_LUI=10.
  - load size codes.
  - entry struct typedef.
- One sub-module, wb_load_ext, holds the combinational byte/half extension; it is instantiated only under LOAD_EXT_EN.

Test Plan:
- Reset, then ALU rd=8 data=0x0000_0005 -> next edge wb_regwrite=01, wb_addr=8, wb_data=5; the cycle after, wb_regwrite=00.
- LUI rd=9 data=0x0000_1234 -> wb_regwrite=10, wb_addr=9, wb_data[15:0]=0x1234; ALU rd=0 -> wb_regwrite=00.
- LOAD rd=10, then ALU rd=11, with mem_rvalid 3 cycles later (0xDEADBEEF) -> r10 written first, r11 the next cycle. pending_mask = 0x0000_0C00 until the r10 write, then 0x0000_0800.
- Hold the load beat and issue 4 enqueues with DEPTH=4 -> in_ready=0. The fifth in_valid is not accepted until the first retire; no entry is lost or reordered.
- mem_rvalid with empty queue -> err_sticky=1 and no write. Assert rst_n low mid-queue -> err_sticky=0, wb_regwrite=00, pending_mask=0 immediately.
- With LOAD_EXT_EN: byte signed load with mem_rdata=0x0000_0080 -> wb_data=0xFFFF_FF80. Half unsigned load with mem_rdata=0x1234_8001 -> wb_data=0x0000_8001.
